// File: rtl/rename_fl_unit.sv
// Register-rename stage: speculative RAT, committed RRAT and a circular free list.
// Takes one rename per cycle, returns registers at commit, and restores from the RRAT on flush.
module rename_fl_unit #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_ps1,
  output logic [PW-1:0] out_ps2,
  output logic [PW-1:0] out_pd,
  output logic [PW-1:0] out_old_pd,
  output logic          out_alloc,
  input  logic          commit_valid,
  input  logic [AW-1:0] commit_rd,
  input  logic [PW-1:0] commit_pd,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned FW       = $clog2(FL_DEPTH);

  logic [PW-1:0] rat      [ARCH_REGS];
  logic [PW-1:0] rrat     [ARCH_REGS];
  logic [PW-1:0] rrat_nxt [ARCH_REGS];
  logic [PW-1:0] fl       [FL_DEPTH];
  logic [FW-1:0] head;
  logic [FW-1:0] commit_head;
  logic [FW-1:0] tail;

  logic need;
  logic accept;
  logic commit_en;
  logic [FW-1:0] commit_head_nxt;

  // Handshake and allocation decode, from registered state only
  always_comb begin
    need      = in_rd_we && (in_rd != '0);
    in_ready  = !flush && (!out_valid || out_ready) && (!need || (free_count != '0));
    accept    = in_valid && in_ready;
    commit_en = commit_valid && (commit_rd != '0);
    commit_head_nxt = commit_en ? commit_head + 1'b1 : commit_head;
  end

  // Committed map after this cycle's commit; forwarded into the RAT on flush
  always_comb begin
    rrat_nxt = rrat;
    if (commit_en) rrat_nxt[commit_rd] = commit_pd;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i]  <= PW'(i);
        rrat[i] <= PW'(i);
      end
      for (int k = 0; k < FL_DEPTH; k++) fl[k] <= PW'(ARCH_REGS + k);
      head        <= '0;
      commit_head <= '0;
      tail        <= '0;
      free_count  <= (PW+1)'(FL_DEPTH);
      out_valid   <= 1'b0;
      out_ps1     <= '0;
      out_ps2     <= '0;
      out_pd      <= '0;
      out_old_pd  <= '0;
      out_alloc   <= 1'b0;
    end else begin
      // Retire: the previous committed mapping of rd becomes free
      if (commit_en) begin
        fl[tail] <= rrat[commit_rd];
        tail     <= tail + 1'b1;
      end
      commit_head <= commit_head_nxt;
      rrat        <= rrat_nxt;

      if (flush) begin
        rat        <= rrat_nxt;
        head       <= commit_head_nxt;
        free_count <= (PW+1)'(FL_DEPTH);
        out_valid  <= 1'b0;
      end else begin
        free_count <= free_count - (PW+1)'(accept && need) + (PW+1)'(commit_en);
        if (accept) begin
          out_valid <= 1'b1;
          out_ps1   <= (in_rs1 == '0) ? '0 : rat[in_rs1];
          out_ps2   <= (in_rs2 == '0) ? '0 : rat[in_rs2];
          if (need) begin
            out_pd     <= fl[head];
            out_old_pd <= rat[in_rd];
            out_alloc  <= 1'b1;
            rat[in_rd] <= fl[head];
            head       <= head + 1'b1;
          end else begin
            out_pd     <= '0;
            out_old_pd <= '0;
            out_alloc  <= 1'b0;
          end
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_fl_unit.sv
// Directed bench for rename_fl_unit: allocation, exhaustion, backpressure, commit and flush.
module tb_rename_fl_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rd_we;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic          out_alloc;
  logic          commit_valid;
  logic [AW-1:0] commit_rd;
  logic [PW-1:0] commit_pd;
  logic          flush;
  logic [PW:0]   free_count;

  int checks = 0;
  int errors = 0;

  rename_fl_unit dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
    .out_alloc(out_alloc),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input int rs1, input int rs2, input int rd, input logic we);
    in_valid = v;
    in_rs1   = AW'(rs1);
    in_rs2   = AW'(rs2);
    in_rd    = AW'(rd);
    in_rd_we = we;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req(1'b0, 0, 0, 0, 1'b0);
    out_ready = 1'b1; commit_valid = 1'b0; commit_rd = '0; commit_pd = '0; flush = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_out_pd", int'(out_pd), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic rename and back-to-back rd=3
    req(1'b1, 1, 2, 3, 1'b1); tick();
    chk("r1_valid", int'(out_valid), 1);
    chk("r1_ps1", int'(out_ps1), 1);
    chk("r1_ps2", int'(out_ps2), 2);
    chk("r1_pd", int'(out_pd), 32);
    chk("r1_old", int'(out_old_pd), 3);
    chk("r1_alloc", int'(out_alloc), 1);
    chk("r1_fc", int'(free_count), 31);
    req(1'b1, 3, 0, 3, 1'b1); tick();
    chk("r2_ps1", int'(out_ps1), 32);
    chk("r2_ps2", int'(out_ps2), 0);
    chk("r2_pd", int'(out_pd), 33);
    chk("r2_old", int'(out_old_pd), 32);
    req(1'b1, 3, 1, 0, 1'b1); tick();
    chk("r3_valid", int'(out_valid), 1);
    chk("r3_alloc", int'(out_alloc), 0);
    chk("r3_pd", int'(out_pd), 0);
    chk("r3_ps1", int'(out_ps1), 33);
    chk("r3_fc", int'(free_count), 30);
    req(1'b0, 0, 0, 0, 1'b0); tick();
    chk("drain_valid", int'(out_valid), 0);

    // Exhaust the free list
    do_reset();
    for (int i = 0; i < 32; i++) begin
      req(1'b1, 0, 0, (i % 31) + 1, 1'b1);
      tick();
    end
    chk("ex_fc", int'(free_count), 0);
    chk("ex_last_pd", int'(out_pd), 63);
    req(1'b1, 0, 0, 4, 1'b1); #1;
    chk("ex_stall_ready", int'(in_ready), 0);
    req(1'b1, 0, 0, 4, 1'b0); #1;
    chk("ex_nowr_ready", int'(in_ready), 1);
    tick();
    chk("ex_nowr_valid", int'(out_valid), 1);
    chk("ex_nowr_alloc", int'(out_alloc), 0);
    chk("ex_nowr_fc", int'(free_count), 0);
    req(1'b0, 0, 0, 0, 1'b0);
    commit_valid = 1'b1; commit_rd = 5'd3; commit_pd = 6'd32;
    tick();
    commit_valid = 1'b0;
    chk("ex_commit_fc", int'(free_count), 1);
    req(1'b1, 0, 0, 7, 1'b1); #1;
    chk("ex_commit_ready", int'(in_ready), 1);
    tick();
    chk("ex_realloc_pd", int'(out_pd), 3);
    chk("ex_realloc_fc", int'(free_count), 0);

    // Backpressure
    do_reset();
    req(1'b1, 0, 0, 1, 1'b1); tick();
    chk("bp_pd0", int'(out_pd), 32);
    out_ready = 1'b0;
    req(1'b1, 0, 0, 2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", int'(in_ready), 0);
      tick();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_pd", int'(out_pd), 32);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", int'(in_ready), 1);
    tick();
    chk("bp_pd1", int'(out_pd), 33);
    chk("bp_old1", int'(out_old_pd), 2);
    req(1'b1, 0, 0, 3, 1'b1); tick();
    chk("bp_pd2", int'(out_pd), 34);
    req(1'b0, 0, 0, 0, 1'b0); tick();
    chk("bp_drain_valid", int'(out_valid), 0);
    chk("bp_fc", int'(free_count), 29);

    // Commit then flush
    do_reset();
    req(1'b1, 0, 0, 5, 1'b1); tick();
    req(1'b1, 0, 0, 6, 1'b1); tick();
    chk("fl_pd6", int'(out_pd), 33);
    req(1'b0, 0, 0, 0, 1'b0);
    commit_valid = 1'b1; commit_rd = 5'd5; commit_pd = 6'd32;
    tick();
    commit_valid = 1'b0;
    chk("fl_commit_fc", int'(free_count), 31);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("fl_valid", int'(out_valid), 0);
    chk("fl_fc", int'(free_count), 32);
    req(1'b1, 5, 6, 7, 1'b1); tick();
    chk("fl_rat5", int'(out_ps1), 32);
    chk("fl_rat6", int'(out_ps2), 6);
    chk("fl_next_pd", int'(out_pd), 33);
    chk("fl_next_old", int'(out_old_pd), 7);

    // Flush together with commit and a request
    do_reset();
    req(1'b1, 0, 0, 5, 1'b1); tick();
    chk("fc_pd5", int'(out_pd), 32);
    flush = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd5; commit_pd = 6'd32;
    req(1'b1, 0, 0, 6, 1'b1); #1;
    chk("fc_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0; commit_valid = 1'b0;
    req(1'b0, 0, 0, 0, 1'b0); #1;
    chk("fc_valid", int'(out_valid), 0);
    chk("fc_fc", int'(free_count), 32);
    req(1'b1, 5, 6, 8, 1'b1); tick();
    chk("fc_rat5", int'(out_ps1), 32);
    chk("fc_rat6", int'(out_ps2), 6);
    chk("fc_next_pd", int'(out_pd), 33);
    chk("fc_fc2", int'(free_count), 31);
    req(1'b0, 0, 0, 0, 1'b0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_fl_unit.md
Name: rename_fl_unit

Overview:
Clocked, parametrised register-rename stage.
- Maps architectural source and destination registers to physical registers using a speculative RAT, a committed RAT (RRAT) and a circular free list.
- Accepts one instruction per cycle over a valid/ready handshake and presents registered results to the dispatch/reservation-station stage.
- Returns physical registers to the free list at commit and restores the speculative state from committed state on flush.

Parameters:
- ARCH_REGS, 32, number of architectural registers; x0 is hard-wired.
- PHYS_REGS, 64, number of physical registers; PHYS_REGS-ARCH_REGS must be a power of two ≥2.
- AW, $clog2(ARCH_REGS), architectural index width (localparam).
- PW, $clog2(PHYS_REGS), physical index width (localparam).
- FL_DEPTH, PHYS_REGS-ARCH_REGS, free-list entries (localparam).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rstn, in, 1, reset, synchronous, active-low.
- in_valid, in, 1, rename request valid.
- in_ready, out, 1, rename request accepted this cycle when in_valid is also high.
- in_rs1, in, AW, source 1 architectural index.
- in_rs2, in, AW, source 2 architectural index.
- in_rd, in, AW, destination architectural index.
- in_rd_we, in, 1, instruction writes rd.
- out_valid, out, 1, renamed result valid.
- out_ready, in, 1, downstream accepts the result.
- out_ps1, out, PW, physical source 1.
- out_ps2, out, PW, physical source 2.
- out_pd, out, PW, newly allocated physical destination.
- out_old_pd, out, PW, previous mapping of rd, carried to the ROB.
- out_alloc, out, 1, a physical register was allocated.
- commit_valid, in, 1, oldest instruction with an allocation retires.
- commit_rd, in, AW, its architectural rd.
- commit_pd, in, PW, its physical rd.
- flush, in, 1, squash all uncommitted renames.
- free_count, out, PW+1, number of free physical registers.

Behaviour:
Reset (rstn=0 at clk edge), overriding all other inputs:
- RAT[i]=RRAT[i]=i.
- Free list entry k = ARCH_REGS+k; head=commit_head=tail=0.
- free_count=FL_DEPTH.
- out_valid=0, and out_ps1, out_ps2, out_pd, out_old_pd, out_alloc all 0.

Allocation condition:
- need = in_rd_we && (in_rd!=0).
- in_ready = !flush && (!out_valid || out_ready) && (!need || free_count!=0).
- in_ready is combinational from registered state only; there is no same-cycle bypass of a commit free into free_count.

Accept (in_valid && in_ready), 1-cycle latency; the output registers load on the same edge:
- out_ps1 = RAT[in_rs1], out_ps2 = RAT[in_rs2]. Sources read the pre-update RAT, so rd==rs1 yields the old mapping. Index 0 always yields 0.
- If need:
  - out_pd = FL[head] and out_old_pd = RAT[in_rd].
  - RAT[in_rd] = FL[head]; head++ (mod FL_DEPTH); out_alloc = 1.
- Otherwise out_pd = 0, out_old_pd = 0, out_alloc = 0, and no state changes.
- out_valid = 1.

Output handshake:
- If out_valid && out_ready && !accept, then out_valid = 0.
- If out_valid && !out_ready, all out_* hold.

Commit (commit_valid):
- FL[tail] = RRAT[commit_rd]; tail++.
- RRAT[commit_rd] = commit_pd; commit_head++.
- commit_rd==0 is illegal: ignore it, with no state change.

free_count:
- Next value = free_count − (accept && need) + (commit_valid).
- The decrement and increment are both applied in the same cycle when both occur.

Flush:
- Has priority over accept; in_ready=0 that cycle.
- out_valid = 0.
- RAT = RRAT, including any commit in the same cycle (the RRAT write is forwarded).
- head = commit_head after that cycle's commit increment.
- free_count = FL_DEPTH.

Invariants and boundaries:
- The number of entries from commit_head to tail equals FL_DEPTH at all times.
- Pointers wrap modulo FL_DEPTH.
- free_count==0 stalls only instructions that need a destination; non-writing instructions still pass.
- p0 is never allocated or freed.

Test Plan:
- Reset, then rename (rs1=1, rs2=2, rd=3, we=1) → next cycle out_valid=1, ps1=1, ps2=2, pd=32, old_pd=3, free_count=31.
- Back-to-back rd=3 twice, second with rs1=3 → second result ps1=32, pd=33, old_pd=32. A following rd=0, we=1 gives out_alloc=0 and pd=0.
- 32 allocating renames with no commits → free_count=0, in_ready=0 for the 33rd allocating request. A non-writing request is still accepted. A commit (rd=3, pd=32) frees p3 → next cycle in_ready=1 and the next allocation yields pd=3.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → exactly one accept per cycle, with no lost or duplicated results.
- Rename rd=5→p32 and rd=6→p33, commit rd=5 (pd=32), then flush → RAT[5]=32, RAT[6]=6, free_count=32, and the next allocation yields p33.
- Flush asserted in the same cycle as commit_valid and in_valid → request not accepted, commit applied, out_valid=0 next cycle, RAT equals the updated RRAT.
